pe_8_elem: RTL and testbench

Eight-lane signed int8 multiply-accumulate processing element, the building block of the systolic 3×3 convolution row. Each valid beat, it forms the dot product of eight activation bytes and eight kernel bytes and accumulates it across a kernel window, for example 36 beats for 3×3×32 channels / 8. On the final beat it publishes the window sum on `out_sum` and clears the accumulator. Neighbouring PEs in a row receive the same stream delayed by one cycle per PE.

---
 rtl/pe_pkg.sv | 8 +
 rtl/pe_dot8.sv | 43 ++++
 rtl/pe_8_elem.sv | 95 +++++++++
 tb/tb_pe_8_elem.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/pe_pkg.sv
// Shared widths for the int8 multiply-accumulate processing element.
package pe_pkg;
    localparam int ELE_BITS  = 8;
    localparam int OUT_BITS  = 32;
    localparam int PROD_BITS = 2 * ELE_BITS;
    localparam int DOT_BITS  = PROD_BITS + 3;
    localparam int PE_LANES  = 8;
endpackage

// File: rtl/pe_dot8.sv
// Eight registered signed lane multipliers followed by a balanced adder tree.
// The dot product is combinational from the product registers.
module pe_dot8
    import pe_pkg::*;
#(
    parameter int ELE_BITS = pe_pkg::ELE_BITS
) (
    input  logic                           clk_i,
    input  logic                           rst_ni,
    input  logic [PE_LANES*ELE_BITS-1:0]   act_i,
    input  logic [PE_LANES*ELE_BITS-1:0]   ker_i,
    output logic signed [2*ELE_BITS+2:0]   dot_o
);
    localparam int PROD_W = 2 * ELE_BITS;
    localparam int DOT_W  = PROD_W + 3;

    logic signed [PROD_W-1:0] prod_q [PE_LANES];
    logic signed [PROD_W:0]   sum1   [4];
    logic signed [PROD_W+1:0] sum2   [2];

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < PE_LANES; i++) prod_q[i] <= '0;
        end else begin
            for (int i = 0; i < PE_LANES; i++) begin
                prod_q[i] <= PROD_W'($signed(act_i[i*ELE_BITS +: ELE_BITS]))
                           * PROD_W'($signed(ker_i[i*ELE_BITS +: ELE_BITS]));
            end
        end
    end

    // Each tree level grows by one bit so no intermediate sum can overflow.
    always_comb begin
        for (int i = 0; i < 4; i++) begin
            sum1[i] = (PROD_W+1)'(prod_q[2*i]) + (PROD_W+1)'(prod_q[2*i+1]);
        end
        for (int i = 0; i < 2; i++) begin
            sum2[i] = (PROD_W+2)'(sum1[2*i]) + (PROD_W+2)'(sum1[2*i+1]);
        end
    end

    assign dot_o = DOT_W'(sum2[0]) + DOT_W'(sum2[1]);
endmodule

// File: rtl/pe_8_elem.sv
// Eight-lane signed MAC processing element: multiply stage, then reduce and
// accumulate over a kernel window, publishing the window sum on the final beat.
module pe_8_elem
    import pe_pkg::*;
#(
    parameter int ELE_BITS = pe_pkg::ELE_BITS,
    parameter int OUT_BITS = pe_pkg::OUT_BITS
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [ELE_BITS-1:0] act_0,
    input  logic [ELE_BITS-1:0] act_1,
    input  logic [ELE_BITS-1:0] act_2,
    input  logic [ELE_BITS-1:0] act_3,
    input  logic [ELE_BITS-1:0] act_4,
    input  logic [ELE_BITS-1:0] act_5,
    input  logic [ELE_BITS-1:0] act_6,
    input  logic [ELE_BITS-1:0] act_7,
    input  logic [ELE_BITS-1:0] ker_0,
    input  logic [ELE_BITS-1:0] ker_1,
    input  logic [ELE_BITS-1:0] ker_2,
    input  logic [ELE_BITS-1:0] ker_3,
    input  logic [ELE_BITS-1:0] ker_4,
    input  logic [ELE_BITS-1:0] ker_5,
    input  logic [ELE_BITS-1:0] ker_6,
    input  logic [ELE_BITS-1:0] ker_7,
    input  logic                valid_in,
    input  logic                final_in,
    output logic                valid_out,
    output logic [OUT_BITS-1:0] out_sum
);
    localparam int DOT_W = 2 * ELE_BITS + 3;

    // valid_in qualifies a beat; there is no ready, so every valid beat is
    // consumed in the cycle it is presented. final_in counts only with valid_in.
    logic [PE_LANES*ELE_BITS-1:0] act_flat;
    logic [PE_LANES*ELE_BITS-1:0] ker_flat;
    logic signed [DOT_W-1:0]      dot;
    logic [OUT_BITS-1:0]          dot_ext;

    logic                valid_q;
    logic                final_q;
    logic [OUT_BITS-1:0] acc_q,  acc_d;
    logic [OUT_BITS-1:0] out_q,  out_d;
    logic                vout_q, vout_d;

    assign act_flat = {act_7, act_6, act_5, act_4, act_3, act_2, act_1, act_0};
    assign ker_flat = {ker_7, ker_6, ker_5, ker_4, ker_3, ker_2, ker_1, ker_0};

    pe_dot8 #(
        .ELE_BITS (ELE_BITS)
    ) u_dot8 (
        .clk_i  (clk),
        .rst_ni (reset),
        .act_i  (act_flat),
        .ker_i  (ker_flat),
        .dot_o  (dot)
    );

    assign dot_ext = OUT_BITS'(dot);

    always_comb begin
        acc_d  = acc_q;
        out_d  = out_q;
        vout_d = 1'b0;
        if (valid_q) begin
            if (final_q) begin
                out_d  = acc_q + dot_ext;
                acc_d  = '0;
                vout_d = 1'b1;
            end else begin
                acc_d  = acc_q + dot_ext;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            valid_q <= 1'b0;
            final_q <= 1'b0;
            acc_q   <= '0;
            out_q   <= '0;
            vout_q  <= 1'b0;
        end else begin
            valid_q <= valid_in;
            final_q <= valid_in & final_in;
            acc_q   <= acc_d;
            out_q   <= out_d;
            vout_q  <= vout_d;
        end
    end

    assign out_sum   = out_q;
    assign valid_out = vout_q;
endmodule

// File: tb/tb_pe_8_elem.sv
// Directed bench for pe_8_elem: hand-computed window sums checked through a
// scoreboard queue that is drained on every valid_out pulse.
module tb_pe_8_elem;
    logic        clk = 1'b0;
    logic        rst_n;
    logic [7:0]  act_drv [8];
    logic [7:0]  ker_drv [8];
    logic [7:0]  act_nxt [8];
    logic [7:0]  ker_nxt [8];
    logic        valid_in;
    logic        final_in;
    logic        valid_out;
    logic [31:0] out_sum;

    int          n_checks = 0;
    int          n_errors = 0;
    int          n_pulses = 0;
    logic [31:0] exp_q [$];

    always #5 clk = ~clk;

    pe_8_elem dut (
        .clk       (clk),
        .reset     (rst_n),
        .act_0     (act_drv[0]),
        .act_1     (act_drv[1]),
        .act_2     (act_drv[2]),
        .act_3     (act_drv[3]),
        .act_4     (act_drv[4]),
        .act_5     (act_drv[5]),
        .act_6     (act_drv[6]),
        .act_7     (act_drv[7]),
        .ker_0     (ker_drv[0]),
        .ker_1     (ker_drv[1]),
        .ker_2     (ker_drv[2]),
        .ker_3     (ker_drv[3]),
        .ker_4     (ker_drv[4]),
        .ker_5     (ker_drv[5]),
        .ker_6     (ker_drv[6]),
        .ker_7     (ker_drv[7]),
        .valid_in  (valid_in),
        .final_in  (final_in),
        .valid_out (valid_out),
        .out_sum   (out_sum)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, $signed(got), $signed(exp));
        end
    endtask

    // Scoreboard: every valid_out pulse must match the oldest expected sum.
    always @(negedge clk) begin
        if (rst_n === 1'b1 && valid_out === 1'b1) begin
            n_pulses++;
            if (exp_q.size() == 0) check("spurious_valid_out", 32'(valid_out), 32'd0);
            else                   check("out_sum", out_sum, exp_q.pop_front());
        end
    end

    task automatic stage_all(input int a, input int k);
        for (int i = 0; i < 8; i++) begin
            act_nxt[i] = 8'(a);
            ker_nxt[i] = 8'(k);
        end
    endtask

    // Lane 0 carries the value with kernel 1; other lanes contribute zero.
    task automatic stage_lane0(input int a);
        for (int i = 0; i < 8; i++) begin
            act_nxt[i] = 8'd0;
            ker_nxt[i] = 8'd1;
        end
        act_nxt[0] = 8'(a);
    endtask

    task automatic beat(input logic v, input logic f);
        @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            act_drv[i] = act_nxt[i];
            ker_drv[i] = ker_nxt[i];
        end
        valid_in = v;
        final_in = f;
    endtask

    task automatic drain(input string tag);
        beat(1'b0, 1'b0);
        for (int i = 0; i < 8 && exp_q.size() != 0; i++) @(negedge clk);
        check({"drain_", tag}, 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not reach its end");
        $fatal(1);
    end

    initial begin
        rst_n    = 1'b0;
        valid_in = 1'b0;
        final_in = 1'b0;
        for (int i = 0; i < 8; i++) begin
            act_drv[i] = 8'd0;
            ker_drv[i] = 8'd0;
            act_nxt[i] = 8'd0;
            ker_nxt[i] = 8'd0;
        end
        repeat (2) @(negedge clk);
        check("reset_out_sum", out_sum, 32'd0);
        check("reset_valid_out", 32'(valid_out), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        beat(1'b0, 1'b0);

        // Single-beat window with exact two-cycle latency.
        stage_all(1, 2);
        exp_q.push_back(32'd16);
        beat(1'b1, 1'b1);
        beat(1'b0, 1'b0);
        check("latency_cycle1_vout", 32'(valid_out), 32'd0);
        @(negedge clk);
        check("latency_cycle2_vout", 32'(valid_out), 32'd1);
        drain("single");
        repeat (3) @(negedge clk);
        check("hold_out_sum", out_sum, 32'd16);
        check("hold_valid_out", 32'(valid_out), 32'd0);

        // Signed extremes.
        stage_all(-128, -128);
        exp_q.push_back(32'd131072);
        beat(1'b1, 1'b1);
        drain("neg_neg");
        stage_all(127, -128);
        exp_q.push_back(32'(-130048));
        beat(1'b1, 1'b1);
        drain("pos_neg");

        // Distinct lanes: 1-4+9-16+25-36+49-64 = -36.
        for (int i = 0; i < 8; i++) begin
            act_nxt[i] = (i % 2 == 0) ? 8'(i + 1) : 8'(-(i + 1));
            ker_nxt[i] = 8'(i + 1);
        end
        exp_q.push_back(32'(-36));
        beat(1'b1, 1'b1);
        drain("mixed_lanes");

        // 36-beat window, 1+2+...+36 = 666.
        exp_q.push_back(32'd666);
        for (int k = 1; k <= 36; k++) begin
            stage_lane0(k);
            beat(1'b1, k == 36);
        end
        drain("window36");

        // Bubbles and a stray final without valid inside the window.
        exp_q.push_back(32'd60);
        stage_lane0(10);
        beat(1'b1, 1'b0);
        beat(1'b0, 1'b0);
        beat(1'b0, 1'b0);
        stage_lane0(20);
        beat(1'b1, 1'b0);
        beat(1'b0, 1'b1);
        beat(1'b0, 1'b0);
        stage_lane0(30);
        beat(1'b1, 1'b1);
        drain("bubbles");
        beat(1'b0, 1'b1);
        repeat (3) beat(1'b0, 1'b0);
        check("final_alone_out_sum", out_sum, 32'd60);
        check("final_alone_pulses", 32'(n_pulses), 32'd6);

        // Back-to-back windows: 5+7 then 9 with no bubble.
        exp_q.push_back(32'd12);
        exp_q.push_back(32'd9);
        stage_lane0(5);
        beat(1'b1, 1'b0);
        stage_lane0(7);
        beat(1'b1, 1'b1);
        stage_lane0(9);
        beat(1'b1, 1'b1);
        beat(1'b0, 1'b0);
        check("b2b_first_vout", 32'(valid_out), 32'd1);
        @(negedge clk);
        check("b2b_second_vout", 32'(valid_out), 32'd1);
        drain("back_to_back");

        // Reset mid-window discards the partial sum and in-flight beats.
        stage_lane0(4);
        repeat (5) beat(1'b1, 1'b0);
        @(negedge clk);
        valid_in = 1'b0;
        rst_n    = 1'b0;
        #1;
        check("midreset_out_sum", out_sum, 32'd0);
        check("midreset_valid_out", 32'(valid_out), 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        exp_q.push_back(32'd3);
        stage_lane0(3);
        beat(1'b1, 1'b1);
        drain("after_reset");

        check("pulse_count", 32'(n_pulses), 32'd9);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
